// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: loader FSM states and stream byte width.
package prog_loader_pkg;

    localparam int BYTE_W      = 8;
    localparam int WORD_BYTES  = 4;
    localparam int WORD_W      = BYTE_W * WORD_BYTES;
    localparam int LEN_W       = 16;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 14
);
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_gnt;

    // Loader side: consumes the byte stream and masters the memory write.
    modport master (
        input  in_data, in_valid, mem_gnt,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    // Environment side: byte source and instruction memory.
    modport slave (
        output in_data, in_valid, mem_gnt,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Collects four stream bytes, LSB first, into one little-endian 32-bit word.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_byte_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_word_done,
    output logic [WORD_W-1:0] o_word
);
    logic [1:0]            r_cnt;
    logic [3*BYTE_W-1:0]   r_shift;

    // The fourth byte completes the word combinationally so it can be latched on that same edge.
    assign o_word_done = i_byte_en && (r_cnt == 2'd3);
    assign o_word      = {i_byte, r_shift};

    // Byte counter wraps 3 -> 0 on the completing byte; earlier bytes shift down toward bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_byte_en) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {i_byte, r_shift[3*BYTE_W-1:BYTE_W]};
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length-prefixed byte frame and writes the
// assembled instruction words into instruction memory, holding the core in reset until done.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 14
)
(
    input  logic             clk,
    input  logic             key,
    prog_loader_if.master    bus,
    output logic             core_hold,
    output logic             load_err,
    output logic [LEN_W-1:0] words_loaded
);
    localparam logic [LEN_W:0] DEPTH = (LEN_W+1)'(1) << ADDR_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_pending;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [LEN_W-1:0]  r_words;
    logic [LEN_W-1:0]  r_len;

    logic              w_accept;
    logic              w_grant;
    logic              w_last;
    logic              w_byte_en;
    logic              w_word_done;
    logic [WORD_W-1:0] w_word;
    logic [LEN_W-1:0]  w_len_hdr;

    assign w_accept  = bus.in_valid && !r_pending;
    assign w_grant   = r_pending && bus.mem_gnt;
    assign w_len_hdr = {bus.in_data, r_len[BYTE_W-1:0]};
    assign w_last    = (r_words + 16'd1) == r_len;
    assign w_byte_en = w_accept && (r_state == DATA);

    assign bus.in_ready  = !r_pending;
    assign bus.mem_we    = r_pending;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign core_hold     = (r_state != DONE);
    assign load_err      = (r_state == ERR);
    assign words_loaded  = r_words;

    word_assembler u_asm (
        .clk         (clk),
        .rst_n       (key),
        .i_byte_en   (w_byte_en),
        .i_byte      (bus.in_data),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

    // State register.
    always_ff @(posedge clk or negedge key) begin
        if (!key) begin
            r_state <= LEN_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: header parse, length check, and completion on the final grant.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LEN_LO: begin
                if (w_accept) w_state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (w_accept) begin
                    if (w_len_hdr == '0)                w_state_nxt = DONE;
                    else if ({1'b0, w_len_hdr} > DEPTH) w_state_nxt = ERR;
                    else                                w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_grant && w_last) w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    // Header capture, write-request handshake, address and word counters.
    always_ff @(posedge clk or negedge key) begin
        if (!key) begin
            r_len     <= '0;
            r_pending <= 1'b0;
            r_wdata   <= '0;
            r_addr    <= '0;
            r_words   <= '0;
        end else begin
            if ((r_state == LEN_LO) && w_accept) r_len[BYTE_W-1:0] <= bus.in_data;
            if ((r_state == LEN_HI) && w_accept) r_len <= w_len_hdr;
            if (w_word_done) begin
                r_wdata   <= w_word;
                r_pending <= 1'b1;
            end else if (w_grant) begin
                r_pending <= 1'b0;
                r_addr    <= r_addr + ADDR_W'(1);
                r_words   <= r_words + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: one instance at the default depth, one at a 4-word depth.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        key = 1'b0;
    logic [7:0]  d_data = 8'h00;
    logic        d_valid = 1'b0;
    logic        mem_gnt = 1'b0;
    bit          sel2 = 1'b0;

    int          gnt_delay = 0;
    int          wait_cnt = 0;
    int          stab_err = 0;
    int          we_seen = 0;
    logic [15:0] hold_addr = '0;
    logic [31:0] hold_wdata = '0;
    logic [47:0] exp_q[$];
    logic [47:0] wr_q[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(14)) bus14 ();
    prog_loader_if #(.ADDR_W(2))  bus2 ();

    logic        hold14, err14, hold2, err2;
    logic [15:0] wl14, wl2;

    assign bus14.in_data  = d_data;
    assign bus14.in_valid = d_valid;
    assign bus14.mem_gnt  = mem_gnt;
    assign bus2.in_data   = d_data;
    assign bus2.in_valid  = d_valid;
    assign bus2.mem_gnt   = mem_gnt;

    prog_loader #(.ADDR_W(14)) u_dut14 (
        .clk(clk), .key(key), .bus(bus14.master),
        .core_hold(hold14), .load_err(err14), .words_loaded(wl14)
    );

    prog_loader #(.ADDR_W(2)) u_dut2 (
        .clk(clk), .key(key), .bus(bus2.master),
        .core_hold(hold2), .load_err(err2), .words_loaded(wl2)
    );

    logic        m_we, m_rdy, m_hold, m_err;
    logic [15:0] m_addr, m_wl;
    logic [31:0] m_wdata;

    assign m_we    = sel2 ? bus2.mem_we    : bus14.mem_we;
    assign m_rdy   = sel2 ? bus2.in_ready  : bus14.in_ready;
    assign m_hold  = sel2 ? hold2          : hold14;
    assign m_err   = sel2 ? err2           : err14;
    assign m_wl    = sel2 ? wl2            : wl14;
    assign m_wdata = sel2 ? bus2.mem_wdata : bus14.mem_wdata;
    assign m_addr  = sel2 ? {14'd0, bus2.mem_addr} : {2'd0, bus14.mem_addr};

    // Memory model: grants after gnt_delay waiting cycles, records each write that will be taken.
    always @(negedge clk) begin
        if (key && m_we) begin
            we_seen++;
            if (m_rdy) stab_err++;
            if (wait_cnt > 0 && (m_addr !== hold_addr || m_wdata !== hold_wdata)) stab_err++;
            hold_addr  = m_addr;
            hold_wdata = m_wdata;
            if (wait_cnt >= gnt_delay) begin
                mem_gnt  = 1'b1;
                wr_q.push_back({m_addr, m_wdata});
                wait_cnt = 0;
            end else begin
                mem_gnt  = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_gnt  = (gnt_delay == 0);
            wait_cnt = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            d_data  = b;
            d_valid = 1'b1;
            if (m_rdy) done = 1'b1;
            @(posedge clk);
        end
        #1 d_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL byte_accept data=%h not accepted within 64 cycles", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        key     = 1'b0;
        d_valid = 1'b0;
        @(negedge clk);
        key = 1'b1;
        exp_q.delete();
        wr_q.delete();
        we_seen  = 0;
        stab_err = 0;
    endtask

    task automatic wait_release(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!m_hold) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        sel2 = 1'b0;
        key  = 1'b0;
        #1;
        total += 7;
        if (m_hold !== 1'b1)   begin bad++; $display("FAIL rst_hold got=%b exp=1", m_hold); end
        if (m_we !== 1'b0)     begin bad++; $display("FAIL rst_we got=%b exp=0", m_we); end
        if (m_addr !== 16'h0)  begin bad++; $display("FAIL rst_addr got=%h exp=0", m_addr); end
        if (m_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", m_wdata); end
        if (m_err !== 1'b0)    begin bad++; $display("FAIL rst_err got=%b exp=0", m_err); end
        if (m_wl !== 16'h0)    begin bad++; $display("FAIL rst_words got=%h exp=0", m_wl); end
        if (m_rdy !== 1'b1)    begin bad++; $display("FAIL rst_ready got=%b exp=1", m_rdy); end
        @(negedge clk);
        key = 1'b1;
    endtask

    task automatic test_basic();
        logic [47:0] e, a;
        sel2 = 1'b0; gnt_delay = 0;
        apply_reset();
        exp_q.push_back({16'd0, 32'h00500013});
        exp_q.push_back({16'd1, 32'h00A00093});
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h00500013);
        send_word(32'h00A00093);
        @(negedge clk);
        total += 2;
        if (m_we !== 1'b1)   begin bad++; $display("FAIL basic_we_last got=%b exp=1", m_we); end
        if (m_hold !== 1'b1) begin bad++; $display("FAIL basic_hold_pre got=%b exp=1", m_hold); end
        @(negedge clk);
        total += 3;
        if (m_hold !== 1'b0) begin bad++; $display("FAIL basic_hold_post got=%b exp=0", m_hold); end
        if (m_we !== 1'b0)   begin bad++; $display("FAIL basic_we_post got=%b exp=0", m_we); end
        if (m_wl !== 16'd2)  begin bad++; $display("FAIL basic_words got=%0d exp=2", m_wl); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (wr_q.size() == 0) begin bad++; $display("FAIL basic_write missing exp=%h", e); end
            else begin
                a = wr_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL basic_write got=%h exp=%h", a, e); end
            end
        end
        total++;
        if (wr_q.size() != 0) begin bad++; $display("FAIL basic_extra got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_wait_gnt();
        logic [47:0] e, a;
        bit ok;
        sel2 = 1'b0; gnt_delay = 3;
        apply_reset();
        exp_q.push_back({16'd0, 32'h00500013});
        exp_q.push_back({16'd1, 32'h00A00093});
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h00500013);
        send_word(32'h00A00093);
        wait_release(ok);
        total += 4;
        if (!ok)              begin bad++; $display("FAIL wait_release got=hold exp=released"); end
        if (stab_err !== 0)   begin bad++; $display("FAIL wait_stable got=%0d exp=0", stab_err); end
        if (we_seen !== 8)    begin bad++; $display("FAIL wait_we_cycles got=%0d exp=8", we_seen); end
        if (m_wl !== 16'd2)   begin bad++; $display("FAIL wait_words got=%0d exp=2", m_wl); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (wr_q.size() == 0) begin bad++; $display("FAIL wait_write missing exp=%h", e); end
            else begin
                a = wr_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL wait_write got=%h exp=%h", a, e); end
            end
        end
        total++;
        if (wr_q.size() != 0) begin bad++; $display("FAIL wait_extra got=%0d exp=0", wr_q.size()); end
        gnt_delay = 0;
    endtask

    task automatic test_zero_len();
        sel2 = 1'b0; gnt_delay = 0;
        apply_reset();
        send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        total++;
        if (m_hold !== 1'b0) begin bad++; $display("FAIL zero_hold got=%b exp=0", m_hold); end
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        @(negedge clk);
        total += 4;
        if (we_seen !== 0)   begin bad++; $display("FAIL zero_we got=%0d exp=0", we_seen); end
        if (m_wl !== 16'd0)  begin bad++; $display("FAIL zero_words got=%0d exp=0", m_wl); end
        if (m_hold !== 1'b0) begin bad++; $display("FAIL zero_hold_after got=%b exp=0", m_hold); end
        if (m_err !== 1'b0)  begin bad++; $display("FAIL zero_err got=%b exp=0", m_err); end
    endtask

    task automatic test_len_err();
        sel2 = 1'b1; gnt_delay = 0;
        apply_reset();
        send_byte(8'h05); send_byte(8'h00);
        @(negedge clk);
        total += 2;
        if (m_err !== 1'b1)  begin bad++; $display("FAIL err_flag got=%b exp=1", m_err); end
        if (m_hold !== 1'b1) begin bad++; $display("FAIL err_hold got=%b exp=1", m_hold); end
        for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
        @(negedge clk);
        total += 3;
        if (we_seen !== 0)   begin bad++; $display("FAIL err_we got=%0d exp=0", we_seen); end
        if (m_err !== 1'b1)  begin bad++; $display("FAIL err_sticky got=%b exp=1", m_err); end
        if (m_hold !== 1'b1) begin bad++; $display("FAIL err_hold_after got=%b exp=1", m_hold); end
        // The same header is in range for the deep instance.
        sel2 = 1'b0;
        apply_reset();
        send_byte(8'h05); send_byte(8'h00);
        @(negedge clk);
        total += 2;
        if (m_err !== 1'b0)  begin bad++; $display("FAIL deep_err got=%b exp=0", m_err); end
        if (m_hold !== 1'b1) begin bad++; $display("FAIL deep_hold got=%b exp=1", m_hold); end
    endtask

    task automatic test_full_depth();
        logic [47:0] e, a;
        logic [31:0] w;
        bit ok;
        sel2 = 1'b1; gnt_delay = 1;
        apply_reset();
        send_byte(8'h04); send_byte(8'h00);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            exp_q.push_back({16'(i), w});
            send_word(w);
        end
        wait_release(ok);
        total += 5;
        if (!ok)              begin bad++; $display("FAIL full_release got=hold exp=released"); end
        if (m_wl !== 16'd4)   begin bad++; $display("FAIL full_words got=%0d exp=4", m_wl); end
        if (m_err !== 1'b0)   begin bad++; $display("FAIL full_err got=%b exp=0", m_err); end
        if (m_addr !== 16'd0) begin bad++; $display("FAIL full_addr_wrap got=%0d exp=0", m_addr); end
        if (stab_err !== 0)   begin bad++; $display("FAIL full_stable got=%0d exp=0", stab_err); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (wr_q.size() == 0) begin bad++; $display("FAIL full_write missing exp=%h", e); end
            else begin
                a = wr_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL full_write got=%h exp=%h", a, e); end
            end
        end
        gnt_delay = 0;
    endtask

    task automatic test_abort();
        logic [47:0] e, a;
        bit ok;
        sel2 = 1'b0; gnt_delay = 0;
        apply_reset();
        exp_q.push_back({16'd0, 32'h00500013});
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h00500013);
        send_byte(8'h93); send_byte(8'h00);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (wr_q.size() == 0) begin bad++; $display("FAIL abort_first missing exp=%h", e); end
        else begin
            a = wr_q.pop_front();
            if (a !== e) begin bad++; $display("FAIL abort_first got=%h exp=%h", a, e); end
        end
        #2 key = 1'b0;
        #1;
        total += 5;
        if (m_hold !== 1'b1)   begin bad++; $display("FAIL abort_hold got=%b exp=1", m_hold); end
        if (m_wl !== 16'h0)    begin bad++; $display("FAIL abort_words got=%0d exp=0", m_wl); end
        if (m_addr !== 16'h0)  begin bad++; $display("FAIL abort_addr got=%h exp=0", m_addr); end
        if (m_wdata !== 32'h0) begin bad++; $display("FAIL abort_wdata got=%h exp=0", m_wdata); end
        if (m_rdy !== 1'b1)    begin bad++; $display("FAIL abort_ready got=%b exp=1", m_rdy); end
        @(negedge clk);
        key = 1'b1;
        wr_q.delete();
        exp_q.push_back({16'd0, 32'hDEADBEEF});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        wait_release(ok);
        total += 2;
        if (!ok)             begin bad++; $display("FAIL abort_release got=hold exp=released"); end
        if (m_wl !== 16'd1)  begin bad++; $display("FAIL abort_reload_words got=%0d exp=1", m_wl); end
        e = exp_q.pop_front();
        total++;
        if (wr_q.size() == 0) begin bad++; $display("FAIL abort_reload missing exp=%h", e); end
        else begin
            a = wr_q.pop_front();
            if (a !== e) begin bad++; $display("FAIL abort_reload got=%h exp=%h", a, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_gnt();
        test_zero_len();
        test_len_err();
        test_full_depth();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
